bram_to_axis_tx: RTL
====================

Name: bram_to_axis_tx

Overview:
- Transmitter end of the BRAM/AXI4-Stream data mover path.
- On a run command, reads i_num_cnt consecutive words from a single-port view of a true dual-port BRAM (addresses 0..N-1, 1-cycle read latency).
- Emits the words as an AXI4-Stream master with full tready backpressure and TLAST on the final beat.
- Feeds downstream stream consumers (e.g. the AXIS-to-BRAM receiver / DMA S2MM).

Parameters:
- DWIDTH, 32, data width of BRAM word and m_axis_tdata
- AWIDTH, 12, BRAM address width; also the width of i_num_cnt
- MEM_SIZE, 4096, BRAM depth in words

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- i_run  in  1  start pulse; sampled only in IDLE
- i_num_cnt  in  AWIDTH  number of words to transfer; latched when i_run is accepted
- o_idle  out  1  high in IDLE
- o_running  out  1  high in RUN
- o_done  out  1  one-cycle pulse in DONE
- addr_b  out  AWIDTH  BRAM address
- ce_b  out  1  BRAM chip enable (read request)
- we_b  out  1  BRAM write enable, constant 0
- q_b  in  DWIDTH  BRAM read data, valid the cycle after ce_b
- m_axis_tdata  out  DWIDTH  stream data
- m_axis_tvalid  out  1  stream valid
- m_axis_tready  in  1  stream ready
- m_axis_tlast  out  1  high on beat N-1

Behaviour:
- Reset values: state IDLE, o_idle=1, all other outputs 0, counters 0, buffer empty. Reset mid-transfer aborts immediately: no o_done pulse, buffer flushed, tvalid drops on the next cycle.
- FSM:
  - IDLE -> RUN when i_run=1 and latched count N>0.
  - IDLE -> DONE when i_run=1 and N=0; no beats, no ce_b.
  - RUN -> DONE on the cycle after the handshake (tvalid & tready) of beat N-1.
  - DONE -> IDLE unconditionally after one cycle.
  - i_run outside IDLE is ignored. i_num_cnt changes after acceptance are ignored.
- Read side:
  - rd_cnt (AWIDTH+1 bits) counts from 0.
  - ce_b=1 with addr_b=rd_cnt when state=RUN, rd_cnt<N, and (occ + inflight − pop) < 2. Here occ is the buffer occupancy (0..2), inflight is ce_b from the previous cycle, and pop = tvalid & tready.
  - rd_cnt increments on each issued read.
  - Combinational outputs addr_b/ce_b are permitted; we_b is always 0.
- Buffer:
  - 2-entry FIFO. Push q_b when inflight=1; pop on handshake. Simultaneous push and pop is legal; occupancy is never exceeded by construction.
- Stream side:
  - m_axis_tvalid = occ>0. m_axis_tdata = FIFO head.
  - tdata/tlast remain stable while tvalid=1 and tready=0 (AXI rule).
  - tx_cnt counts handshakes. m_axis_tlast = tvalid & (tx_cnt == N−1).
  - tvalid never asserts outside RUN.
- Latency (tready=1 throughout; i_run accepted in cycle T0):
  - ce_b for addr 0 in T1; first beat valid in T3.
  - Beats continuous, 1 per cycle: beat k in T3+k.
  - o_done in T3+N; o_idle back in T3+N+1.
- Backpressure: any tready pattern yields exactly N beats in address order, with no loss or duplication. Throughput recovers to 1 beat/cycle one cycle after tready rises.
- N=MEM_SIZE is not representable in AWIDTH; the maximum is 2^AWIDTH−1 words. Address wrap never occurs.

Test Plan:
- BRAM preloaded ram[i]=i, N=3840, tready=1 -> 3840 beats, tdata=0..3839, tlast only on the beat with tdata=3839, first tvalid 3 cycles after i_run, o_done at T3+3840, exactly 3840 ce_b pulses.
- N=16, tready toggles 1,0,1,0… (then random 30% duty) -> 16 beats tdata=0..15 in order; tdata/tlast held while stalled; tlast on beat 15 only.
- N=0 -> o_done pulse at T1, no ce_b, no tvalid, o_idle at T2.
- N=1, tready=0 for 10 cycles then 1 -> single beat tdata=0 with tlast=1 held for 10 stall cycles; exactly 1 ce_b; o_done the cycle after the handshake.
- i_run re-pulsed mid-transfer with i_num_cnt=5 (original N=100) -> ignored; 100 beats delivered; second run with N=5 after o_idle yields 5 beats.
- reset asserted for 1 cycle at beat 50 of N=100 -> tvalid=0 next cycle, no o_done, o_idle=1; subsequent run with N=8 yields tdata=0..7 with correct tlast.

Source files
------------

// File: rtl/bram_to_axis_tx.sv
// bram_to_axis_tx
//   Streams N consecutive words out of a BRAM read port (addresses 0..N-1,
//   one-cycle read latency) as an AXI4-Stream master with full backpressure
//   and TLAST on the final beat.
//
//   A small two-entry skid FIFO sits between the BRAM read port and the
//   stream. Reads are only issued when the FIFO is guaranteed to have room
//   for the word when it returns. This allows one beat per cycle while
//   still tolerating any tready pattern.
//
// Ports
//   clk, reset      rising-edge clock, synchronous active-high reset
//   i_run           start pulse, sampled only in IDLE
//   i_num_cnt       word count N, latched when i_run is accepted
//   o_idle          high in IDLE
//   o_running       high in RUN
//   o_done          one-cycle pulse in DONE
//   addr_b, ce_b    BRAM read address / read request (combinational)
//   we_b            BRAM write enable, tied low
//   q_b             BRAM read data, valid the cycle after ce_b
//   m_axis_*        AXI4-Stream master (tdata, tvalid, tready, tlast)
module bram_to_axis_tx #(
    parameter int DWIDTH   = 32,
    parameter int AWIDTH   = 12,
    parameter int MEM_SIZE = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_run,
    input  logic [AWIDTH-1:0] i_num_cnt,
    output logic              o_idle,
    output logic              o_running,
    output logic              o_done,
    output logic [AWIDTH-1:0] addr_b,
    output logic              ce_b,
    output logic              we_b,
    input  logic [DWIDTH-1:0] q_b,
    output logic [DWIDTH-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast
);

    // Reads are never issued past the physical depth of the memory.
    localparam logic [AWIDTH:0] MEM_LIM = MEM_SIZE[AWIDTH:0];

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [AWIDTH-1:0]   num_q;
    logic [AWIDTH:0]     rd_cnt;
    logic [AWIDTH:0]     tx_cnt;
    logic [AWIDTH:0]     last_idx;
    logic                rd_vld_p1;     // read issued last cycle: q_b valid now
    logic [DWIDTH-1:0]   fifo_mem [2];
    logic                wr_ptr;
    logic                rd_ptr;
    logic [1:0]          occ;
    logic                push;
    logic                pop;
    logic                room;
    logic                start;

    assign start    = (state_q == IDLE) && i_run;
    assign last_idx = {1'b0, num_q} - 1'b1;

    // Stream side
    assign m_axis_tvalid = (state_q == RUN) && (occ != 2'd0);
    assign m_axis_tdata  = fifo_mem[rd_ptr];
    assign m_axis_tlast  = m_axis_tvalid && (tx_cnt == last_idx);

    assign pop  = m_axis_tvalid && m_axis_tready;
    assign push = rd_vld_p1;

    // A new read is safe only if the words already buffered plus the one in
    // flight, minus the one leaving this cycle, leave a free slot.
    assign room = ({1'b0, occ} + {2'b00, rd_vld_p1}) < (3'd2 + {2'b00, pop});

    // Read side
    assign ce_b   = (state_q == RUN) && (rd_cnt < {1'b0, num_q})
                    && (rd_cnt < MEM_LIM) && room;
    assign addr_b = rd_cnt[AWIDTH-1:0];
    assign we_b   = 1'b0;

    always_comb begin
        state_d   = state_q;
        o_idle    = 1'b0;
        o_running = 1'b0;
        o_done    = 1'b0;
        case (state_q)
            IDLE: begin
                o_idle = 1'b1;
                if (i_run) begin
                    state_d = (i_num_cnt == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                o_running = 1'b1;
                if (pop && m_axis_tlast) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                o_done  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            num_q       <= '0;
            rd_cnt      <= '0;
            tx_cnt      <= '0;
            rd_vld_p1   <= 1'b0;
            occ         <= 2'd0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
        end else begin
            state_q <= state_d;

            // Command stage: latch N and restart the counters.
            if (start) begin
                num_q  <= i_num_cnt;
                rd_cnt <= '0;
                tx_cnt <= '0;
            end else begin
                if (ce_b) begin
                    rd_cnt <= rd_cnt + 1'b1;
                end
                if (pop) begin
                    tx_cnt <= tx_cnt + 1'b1;
                end
            end

            // Read-return stage: BRAM data lands one cycle after ce_b.
            rd_vld_p1 <= ce_b;
            if (push) begin
                fifo_mem[wr_ptr] <= q_b;
                wr_ptr           <= ~wr_ptr;
            end

            // Output stage: head of FIFO leaves on handshake.
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule
